hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/hz_sat_counter.sv | 32 +++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared pipeline types and widths for the rv32i core: datapath/address widths,
// forwarding-select and hazard-FSM encodings, and the register-match helper.
package rv32i_pkg;

    localparam int DPW = 32;
    localparam int ADW = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } hz_state_t;

    // x0 is hard-wired to zero, so it can never carry a dependency.
    function automatic logic reg_match(input logic [ADW-1:0] src,
                                       input logic [ADW-1:0] dst,
                                       input logic           we);
        return we && (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// CNT_W-wide up-counter with enable that sticks at all-ones instead of wrapping.
module hz_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: post-reset hold, RAW stall/flush decision, operand forwarding
// and stall/flush performance counters. Define HAZARD_FWD_EN to enable forwarding.
module hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int HOLD_CYC = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [ADW-1:0]   addr_1,
    input  logic [ADW-1:0]   addr_2,
    input  logic [ADW-1:0]   RdE,
    input  logic [ADW-1:0]   RdM,
    input  logic [ADW-1:0]   RdW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             resultsrcE,
    input  logic             branch_takenE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       fwdAE,
    output logic [1:0]       fwdBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int HC_W = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);

    hz_state_t      state_q, state_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic [ADW-1:0] rs1e_q, rs2e_q;
    logic           raw_stall;
    fwd_sel_t       fwd_a_raw, fwd_b_raw;
    fwd_sel_t       fwd_a, fwd_b;
    logic           run;

    assign run = (state_q == RUN);

    // HOLD lasts HOLD_CYC edges after reset release; RUN is absorbing.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (state_q == HOLD) begin
            if (hold_q <= HC_W'(1)) begin
                state_d = RUN;
            end else begin
                hold_d = hold_q - HC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= HOLD;
            hold_q  <= HC_W'(HOLD_CYC);
            rs1e_q  <= '0;
            rs2e_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rs1e_q  <= flushE ? '0 : addr_1;
            rs2e_q  <= flushE ? '0 : addr_2;
        end
    end

`ifdef HAZARD_FWD_EN
    function automatic fwd_sel_t fwd_pick(input logic [ADW-1:0] rs,
                                          input logic [ADW-1:0] rd_m, input logic we_m,
                                          input logic [ADW-1:0] rd_w, input logic we_w);
        if (reg_match(rs, rd_m, we_m)) return FWD_M;
        if (reg_match(rs, rd_w, we_w)) return FWD_W;
        return FWD_RF;
    endfunction

    // With M/W bypass, only a load in E or a W producer (no regfile write-through) must stall.
    assign raw_stall = (resultsrcE && (reg_match(addr_1, RdE, regwriteE) ||
                                       reg_match(addr_2, RdE, regwriteE)))
                     || reg_match(addr_1, RdW, regwriteW)
                     || reg_match(addr_2, RdW, regwriteW);
    assign fwd_a_raw = fwd_pick(rs1e_q, RdM, regwriteM, RdW, regwriteW);
    assign fwd_b_raw = fwd_pick(rs2e_q, RdM, regwriteM, RdW, regwriteW);
`else
    logic unused_fwd_sources;

    assign raw_stall = reg_match(addr_1, RdE, regwriteE) || reg_match(addr_2, RdE, regwriteE)
                    || reg_match(addr_1, RdM, regwriteM) || reg_match(addr_2, RdM, regwriteM)
                    || reg_match(addr_1, RdW, regwriteW) || reg_match(addr_2, RdW, regwriteW);
    assign fwd_a_raw = FWD_RF;
    assign fwd_b_raw = FWD_RF;
    assign unused_fwd_sources = ^{resultsrcE, rs1e_q, rs2e_q};
`endif

    // A taken branch squashes the wrong-path instructions and wins over any stall.
    always_comb begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushD = 1'b0;
        flushE = 1'b1;
        fwd_a  = FWD_RF;
        fwd_b  = FWD_RF;
        if (run) begin
            fwd_a = fwd_a_raw;
            fwd_b = fwd_b_raw;
            if (branch_takenE) begin
                stallF = 1'b0;
                stallD = 1'b0;
                flushD = 1'b1;
                flushE = 1'b1;
            end else begin
                stallF = raw_stall;
                stallD = raw_stall;
                flushE = raw_stall;
            end
        end
    end

    assign fwdAE = fwd_a;
    assign fwdBE = fwd_b;

    hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .en_i   (run && stallD),
        .cnt_o  (stall_cnt)
    );

    hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .en_i   (run && branch_takenE),
        .cnt_o  (flush_cnt)
    );

endmodule
